// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//    Shares one single-port data RAM between the processor load/store path
//    and an external loader/debug port. The processor normally wins. An
//    external requester denied for WAIT_MAX consecutive cycles takes
//    ownership for at most MAX_BURST grants. The processor is stalled while
//    its access is held off.
//
// Ports
//    clk        rising-edge clock
//    reset      asynchronous, active-low reset
//    cpu_*      processor request (req/we/addr/wdata), cpu_rdata is the raw
//               RAM read data, cpu_stall holds the PC this cycle
//    ext_*      external request (held until ext_ack), ext_rdata is the
//               registered read data, valid with the one-cycle ext_ack pulse
//    ram_*      RAM side: write enable, address, write data, async read data
module data_mem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int WAIT_MAX  = 4,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic [DW-1:0] ext_rdata,
   output logic          ext_ack,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int CNT_MAX = (WAIT_MAX > MAX_BURST) ? WAIT_MAX : MAX_BURST;
   localparam int CW      = $clog2(CNT_MAX) + 1;
   localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_MAX - 1);
   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

   typedef enum logic {
      S_CPU = 1'b0,
      S_EXT = 1'b1
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_wait_cnt;
   logic [CW-1:0]   r_burst_cnt;
   logic            r_ext_ack;
   logic [DW-1:0]   r_ext_rdata;

   logic            w_gnt_cpu;
   logic            w_gnt_ext;

   // Grants are forced low while reset is asserted so nothing reaches the
   // RAM during reset, including an access that was in flight.
   always_comb begin
      w_gnt_cpu = 1'b0;
      w_gnt_ext = 1'b0;
      if (reset) begin
         if (r_state == S_CPU) begin
            w_gnt_cpu = cpu_req;
            w_gnt_ext = ext_req & ~cpu_req;
         end else begin
            w_gnt_ext = ext_req;
            w_gnt_cpu = cpu_req & ~ext_req;
         end
      end
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (w_gnt_cpu) begin
         ram_we    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
      end else if (w_gnt_ext) begin
         ram_we    = ext_we;
         ram_addr  = ext_addr;
         ram_wdata = ext_wdata;
      end
   end

   assign cpu_stall = reset & cpu_req & ~w_gnt_cpu;
   assign cpu_rdata = ram_rdata;
   assign ext_ack   = r_ext_ack;
   assign ext_rdata = r_ext_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_CPU;
         r_wait_cnt  <= '0;
         r_burst_cnt <= '0;
         r_ext_ack   <= 1'b0;
         r_ext_rdata <= '0;
      end else begin
         r_ext_ack <= w_gnt_ext;
         if (w_gnt_ext && !ext_we) begin
            r_ext_rdata <= ram_rdata;
         end

         if (r_state == S_CPU) begin
            r_burst_cnt <= '0;
            if (ext_req && !w_gnt_ext) begin
               // Last tolerated denial: hand ownership to the ext port.
               if (r_wait_cnt == WAIT_LAST) begin
                  r_state    <= S_EXT;
                  r_wait_cnt <= '0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end else begin
               r_wait_cnt <= '0;
            end
         end else begin
            r_wait_cnt <= '0;
            // Ownership ends when the ext port goes idle or uses up its burst.
            if (!ext_req || (r_burst_cnt == BURST_LAST)) begin
               r_state     <= S_CPU;
               r_burst_cnt <= '0;
            end else begin
               r_burst_cnt <= r_burst_cnt + 1'b1;
            end
         end
      end
   end

endmodule
